// File: rtl/exception_ctrl.sv
// Commit-point exception arbiter: picks one interrupt/exception/ERET per cycle,
// drives the CP0 exception update, and holds the pipeline flush for FLUSH_CYCLES.
module exception_ctrl #(
  parameter int               FLUSH_CYCLES = 2,
  parameter logic [31:0]      EXC_VECTOR   = 32'hBFC0_0380,
  parameter int               EXC_W        = 32,
  parameter logic [EXC_W-1:0] ERET_CODE    = EXC_W'(32'h0000_000E)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid_i,
  input  logic [31:0]      mem_pc_i,
  input  logic             mem_is_slot_i,
  input  logic [6:0]       mem_flags_i,
  input  logic             cp0_we_i,
  input  logic [4:0]       cp0_waddr_i,
  input  logic [31:0]      cp0_wdata_i,
  input  logic [31:0]      status_i,
  input  logic [31:0]      cause_i,
  input  logic [31:0]      epc_i,
  output logic             exception_en_o,
  output logic             is_exception_o,
  output logic             is_interrupt_o,
  output logic [EXC_W-1:0] excepttype_o,
  output logic [31:0]      exc_pc_o,
  output logic             is_slot_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) + 1 : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      new_pc_reg, new_pc_next;

  logic [31:0] status_f, cause_f, epc_f;
  logic        int_pend;
  logic        evt, int_evt, eret_evt;
  logic [4:0]  code;
  logic [31:0] evt_pc;
  logic        unused_bits;

  // Same-cycle CP0 writes are forwarded; software may only write Cause.IP1..IP0.
  always_comb begin
    status_f = (cp0_we_i && cp0_waddr_i == 5'd12) ? cp0_wdata_i : status_i;
    epc_f    = (cp0_we_i && cp0_waddr_i == 5'd14) ? cp0_wdata_i : epc_i;
    cause_f  = cause_i;
    if (cp0_we_i && cp0_waddr_i == 5'd13)
      cause_f[9:8] = cp0_wdata_i[9:8];
  end

  assign int_pend    = status_f[0] & ~status_f[1] & (|(cause_f[15:8] & status_f[15:8]));
  assign unused_bits = ^{status_f[31:16], status_f[7:2], cause_f[31:16], cause_f[7:0]};

  always_comb begin
    evt      = 1'b0;
    int_evt  = 1'b0;
    eret_evt = 1'b0;
    code     = 5'h00;
    if (rst_n && state_reg == IDLE && mem_valid_i) begin
      evt = 1'b1;
      if (int_pend)            int_evt  = 1'b1;
      else if (mem_flags_i[6]) code     = 5'h04;
      else if (mem_flags_i[5]) code     = 5'h05;
      else if (mem_flags_i[4]) code     = 5'h0A;
      else if (mem_flags_i[3]) code     = 5'h0C;
      else if (mem_flags_i[2]) code     = 5'h08;
      else if (mem_flags_i[1]) code     = 5'h09;
      else if (mem_flags_i[0]) eret_evt = 1'b1;
      else                     evt      = 1'b0;
    end
  end

  assign evt_pc = eret_evt ? epc_f : EXC_VECTOR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      new_pc_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      new_pc_reg <= new_pc_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    new_pc_next = new_pc_reg;
    case (state_reg)
      IDLE: begin
        if (evt && FLUSH_CYCLES > 1) begin
          state_next  = FLUSH;
          cnt_next    = CNT_W'(FLUSH_CYCLES - 1);
          new_pc_next = evt_pc;
        end
      end
      FLUSH: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    exception_en_o = 1'b0;
    is_exception_o = 1'b0;
    is_interrupt_o = 1'b0;
    excepttype_o   = '0;
    exc_pc_o       = '0;
    is_slot_o      = 1'b0;
    flush_o        = 1'b0;
    new_pc_o       = '0;
    if (state_reg == FLUSH) begin
      flush_o  = 1'b1;
      new_pc_o = new_pc_reg;
    end else if (evt) begin
      exception_en_o = 1'b1;
      is_interrupt_o = int_evt;
      is_exception_o = ~int_evt;
      excepttype_o   = eret_evt ? ERET_CODE : EXC_W'(code);
      exc_pc_o       = mem_is_slot_i ? mem_pc_i - 32'd4 : mem_pc_i;
      is_slot_o      = mem_is_slot_i;
      flush_o        = 1'b1;
      new_pc_o       = evt_pc;
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: directed test-plan cases followed by
// random traffic, each cycle predicted by a rule-level reference model.
module tb_exception_ctrl;

  localparam int          FLUSH_CYCLES = 2;
  localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
  localparam logic [31:0] ERET_CODE    = 32'h0000_000E;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_is_slot, cp0_we;
  logic [31:0] mem_pc, cp0_wdata, status, cause, epc;
  logic [6:0]  mem_flags;
  logic [4:0]  cp0_waddr;
  logic        exception_en, is_exception, is_interrupt, is_slot, flush;
  logic [31:0] excepttype, exc_pc, new_pc;

  exception_ctrl #(
    .FLUSH_CYCLES(FLUSH_CYCLES), .EXC_VECTOR(EXC_VECTOR), .EXC_W(32), .ERET_CODE(ERET_CODE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid_i(mem_valid), .mem_pc_i(mem_pc), .mem_is_slot_i(mem_is_slot),
    .mem_flags_i(mem_flags), .cp0_we_i(cp0_we), .cp0_waddr_i(cp0_waddr),
    .cp0_wdata_i(cp0_wdata), .status_i(status), .cause_i(cause), .epc_i(epc),
    .exception_en_o(exception_en), .is_exception_o(is_exception),
    .is_interrupt_o(is_interrupt), .excepttype_o(excepttype), .exc_pc_o(exc_pc),
    .is_slot_o(is_slot), .flush_o(flush), .new_pc_o(new_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en, is_exc, is_int, slot, flush;
    logic [31:0] etype, exc_pc, new_pc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   rem    = 0;
  logic [31:0] held_pc = '0;
  int   prio_code[7] = '{32'h04, 32'h05, 32'h0A, 32'h0C, 32'h08, 32'h09, 32'h0E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: one record per cycle from the current inputs.
  task automatic commit();
    exp_t        e;
    logic [31:0] st, ca, ep;
    bit          ip, hit, is_eret;
    int          code;
    e = '0;
    if (rst_n !== 1'b1) begin
      rem = 0;
    end else if (rem > 0) begin
      e.flush  = 1'b1;
      e.new_pc = held_pc;
      rem--;
    end else if (mem_valid) begin
      st = (cp0_we && cp0_waddr == 5'd12) ? cp0_wdata : status;
      ca = (cp0_we && cp0_waddr == 5'd13) ? ((cause & ~32'h300) | (cp0_wdata & 32'h300)) : cause;
      ep = (cp0_we && cp0_waddr == 5'd14) ? cp0_wdata : epc;
      ip = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'h00);
      hit = ip; code = 0; is_eret = 1'b0;
      for (int b = 6; b >= 0 && !hit; b--) begin
        if (mem_flags[b]) begin
          hit = 1'b1; code = prio_code[6-b]; is_eret = (b == 0);
        end
      end
      if (hit) begin
        e.en     = 1'b1;
        e.is_int = ip;
        e.is_exc = !ip;
        e.etype  = is_eret ? ERET_CODE : 32'(code);
        e.exc_pc = mem_is_slot ? mem_pc - 32'd4 : mem_pc;
        e.slot   = mem_is_slot;
        e.flush  = 1'b1;
        e.new_pc = is_eret ? ep : EXC_VECTOR;
        rem      = FLUSH_CYCLES - 1;
        held_pc  = e.new_pc;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic rst, input logic v, input logic [31:0] pc, input logic sl,
                     input logic [6:0] fl, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [31:0] st, input logic [31:0] ca,
                     input logic [31:0] ep);
    @(posedge clk); #1;
    rst_n = rst; mem_valid = v; mem_pc = pc; mem_is_slot = sl; mem_flags = fl;
    cp0_we = we; cp0_waddr = wa; cp0_wdata = wd; status = st; cause = ca; epc = ep;
    commit();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares DUT outputs against the queued expectation on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("flush", 32'(flush), 32'(e.flush));
        chk("new_pc", new_pc, e.new_pc);
        chk("exception_en", 32'(exception_en), 32'(e.en));
        chk("is_exception", 32'(is_exception), 32'(e.is_exc));
        chk("is_interrupt", 32'(is_interrupt), 32'(e.is_int));
        chk("excepttype", excepttype, e.etype);
        chk("exc_pc", exc_pc, e.exc_pc);
        chk("is_slot", 32'(is_slot), 32'(e.slot));
        if (exception_en)
          $display("event t=%0t int=%0b type=%h exc_pc=%h slot=%0b new_pc=%h",
                   $time, is_interrupt, excepttype, exc_pc, is_slot, new_pc);
      end
    end
  end

  initial begin
    logic [31:0] st_r, ca_r, rpc;
    logic [6:0]  fl_r;
    logic [4:0]  wa_r;
    rst_n = 0; mem_valid = 0; mem_pc = 0; mem_is_slot = 0; mem_flags = 0;
    cp0_we = 0; cp0_waddr = 0; cp0_wdata = 0; status = 0; cause = 0; epc = 0;
    cyc(0, 1, 32'h1000, 0, 7'h7F, 0, 0, 0, 32'hFF01, 32'h8000, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Interrupt with flush hold
    cyc(1, 1, 32'h1000, 0, 0, 0, 0, 0, 32'h0000_FF01, 32'h0000_8000, 0);
    cyc(1, 1, 32'h1004, 0, 0, 0, 0, 0, 32'h0000_FF01, 32'h0000_8000, 0);
    idle(1);
    // Syscall in a delay slot
    cyc(1, 1, 32'h2004, 1, 7'b0000100, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Priority: ov beats bp/eret; interrupt beats all
    cyc(1, 1, 32'h2100, 0, 7'b0001011, 0, 0, 0, 0, 0, 0);
    idle(2);
    cyc(1, 1, 32'h2200, 0, 7'b0001011, 0, 0, 0, 32'h0000_FF01, 32'h0000_0800, 0);
    idle(2);
    // ERET with same-cycle EPC write
    cyc(1, 1, 32'h2300, 0, 7'b0000001, 1, 5'd14, 32'h4000, 0, 0, 32'h3000);
    idle(2);
    // EXL blocks interrupt, then Status forwarding clears it
    cyc(1, 1, 32'h2400, 0, 0, 0, 0, 0, 32'h0000_FF03, 32'h0000_8000, 0);
    cyc(1, 1, 32'h2400, 0, 0, 1, 5'd12, 32'h0000_FF01, 32'h0000_FF03, 32'h0000_8000, 0);
    idle(2);
    // Cause forwarding: only IP1..IP0 are writable
    cyc(1, 1, 32'h2500, 0, 0, 1, 5'd13, 32'h0000_FC00, 32'h0000_FF01, 0, 0);
    cyc(1, 1, 32'h2500, 0, 0, 1, 5'd13, 32'h0000_0100, 32'h0000_FF01, 0, 0);
    idle(2);
    // Invalid instruction: no event even with interrupt and flags
    cyc(1, 0, 32'h2600, 0, 7'h7F, 0, 0, 0, 32'h0000_FF01, 32'h0000_8000, 0);
    // Flags ignored during FLUSH; slot PC wraps
    cyc(1, 1, 32'h0000_0000, 1, 7'b0000100, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h2704, 0, 7'b0010000, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Async reset mid-FLUSH
    cyc(1, 1, 32'h2800, 0, 7'b0000100, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h2804, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       st_r = 32'h0000_FF01;
        1:       st_r = 32'h0000_FF03;
        2:       st_r = 32'h0000_0000;
        default: st_r = $urandom;
      endcase
      ca_r = ($urandom_range(0, 1) == 1) ? ($urandom & 32'h0000_FF00) : 32'h0;
      fl_r = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h00;
      wa_r = ($urandom_range(0, 1) == 1) ? 5'(12 + $urandom_range(0, 2)) : 5'($urandom);
      rpc  = $urandom & 32'hFFFF_FFFC;
      cyc(($urandom_range(0, 99) != 0), 1'($urandom), rpc, 1'($urandom), fl_r,
          1'($urandom), wa_r, $urandom, st_r, ca_r, $urandom);
    end
    idle(3);
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
